// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: generates the shared mic clock and decimates every
// 1-bit PDM stream with a 3rd-order CIC into offset-binary PCM words.
module pdm_cic_decimator #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_MICS   = 9,
    parameter int LOG2_DECIM = 6,
    parameter int PDM_DIV    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_MICS-1:0]  pdm_data_in,
    output logic                 mic_clk,
    output logic [BIT_WIDTH-1:0] pcm_data_out [0:NUM_MICS-1],
    output logic                 pcm_valid
);

    localparam int W     = 3 * LOG2_DECIM + 1;
    localparam int DIV_W = $clog2(PDM_DIV);
    localparam logic [W-1:0] Y_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PDM_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PDM_DIV / 2);

    // ---------------- control ----------------
    logic                  r_en_d;
    logic [DIV_W-1:0]      r_div_cnt;
    logic                  r_mic_clk;
    logic [LOG2_DECIM-1:0] r_dec_cnt;
    logic [1:0]            r_warm_cnt;
    logic                  r_last;
    logic                  r_pcm_valid;

    logic                  w_rise;
    logic [DIV_W-1:0]      w_div_cur;
    logic [DIV_W-1:0]      w_div_next;
    logic [LOG2_DECIM-1:0] w_dec_cur;
    logic [1:0]            w_warm_cur;
    logic                  w_strobe;
    logic                  w_last;
    logic                  w_comb_upd;
    logic                  w_emit;

    // An enable rising edge restarts the divider and the period/warm-up counters
    // in the very cycle enable is first seen high.
    assign w_rise     = enable & ~r_en_d;
    assign w_div_cur  = w_rise ? '0 : r_div_cnt;
    assign w_div_next = (w_div_cur == DIV_LAST) ? '0 : w_div_cur + 1'b1;
    assign w_dec_cur  = w_rise ? '0 : r_dec_cnt;
    assign w_warm_cur = w_rise ? '0 : r_warm_cnt;
    assign w_strobe   = enable & (w_div_cur == DIV_LAST);
    assign w_last     = w_strobe & (w_dec_cur == '1);
    assign w_comb_upd = enable & r_last;
    assign w_emit     = w_comb_upd & (w_warm_cur == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_d      <= 1'b0;
            r_div_cnt   <= '0;
            r_mic_clk   <= 1'b0;
            r_dec_cnt   <= '0;
            r_warm_cnt  <= '0;
            r_last      <= 1'b0;
            r_pcm_valid <= 1'b0;
        end else begin
            r_en_d      <= enable;
            r_pcm_valid <= w_emit;
            if (enable) begin
                r_div_cnt <= w_div_next;
                r_mic_clk <= (w_div_next < DIV_HALF);
                r_last    <= w_last;
                r_dec_cnt <= w_strobe ? w_dec_cur + 1'b1 : w_dec_cur;
                if (w_comb_upd && (w_warm_cur != 2'd3)) begin
                    r_warm_cnt <= w_warm_cur + 2'd1;
                end else begin
                    r_warm_cnt <= w_warm_cur;
                end
            end else begin
                // A final sample still in flight when enable drops is discarded.
                r_mic_clk <= 1'b0;
                r_last    <= 1'b0;
            end
        end
    end

    assign mic_clk   = r_mic_clk;
    assign pcm_valid = r_pcm_valid;

    // ---------------- per-mic CIC datapath ----------------
    logic [W-1:0]         r_i1  [NUM_MICS];
    logic [W-1:0]         r_i2  [NUM_MICS];
    logic [W-1:0]         r_i3  [NUM_MICS];
    logic [W-1:0]         r_d1  [NUM_MICS];
    logic [W-1:0]         r_d2  [NUM_MICS];
    logic [W-1:0]         r_d3  [NUM_MICS];
    logic [BIT_WIDTH-1:0] r_pcm [NUM_MICS];

    logic [W-1:0]         w_i1n [NUM_MICS];
    logic [W-1:0]         w_i2n [NUM_MICS];
    logic [W-1:0]         w_i3n [NUM_MICS];
    logic [W-1:0]         w_c1  [NUM_MICS];
    logic [W-1:0]         w_c2  [NUM_MICS];
    logic [W-1:0]         w_c3  [NUM_MICS];
    logic [BIT_WIDTH-1:0] w_pcm [NUM_MICS];

    // Integrators chain within one sample (i2 sees the new i1, i3 the new i2),
    // so a constant input of ones settles to exactly DECIM^3 at the comb output.
    always_comb begin
        for (int m = 0; m < NUM_MICS; m++) begin
            w_i1n[m] = r_i1[m] + W'(pdm_data_in[m]);
            w_i2n[m] = r_i2[m] + w_i1n[m];
            w_i3n[m] = r_i3[m] + w_i2n[m];
            w_c1[m]  = r_i3[m] - r_d1[m];
            w_c2[m]  = w_c1[m] - r_d2[m];
            w_c3[m]  = w_c2[m] - r_d3[m];
            // Only y == DECIM^3 exceeds Y_MAX; it maps to the all-ones code.
            w_pcm[m] = (w_c3[m] > Y_MAX) ? '1 : w_c3[m][W-2 -: BIT_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < NUM_MICS; m++) begin
                r_i1[m]  <= '0;
                r_i2[m]  <= '0;
                r_i3[m]  <= '0;
                r_d1[m]  <= '0;
                r_d2[m]  <= '0;
                r_d3[m]  <= '0;
                r_pcm[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_MICS; m++) begin
                if (w_strobe) begin
                    r_i1[m] <= w_i1n[m];
                    r_i2[m] <= w_i2n[m];
                    r_i3[m] <= w_i3n[m];
                end
                if (w_comb_upd) begin
                    r_d1[m] <= r_i3[m];
                    r_d2[m] <= w_c1[m];
                    r_d3[m] <= w_c2[m];
                end
                if (w_emit) begin
                    r_pcm[m] <= w_pcm[m];
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < NUM_MICS; m++) begin
            pcm_data_out[m] = r_pcm[m];
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: FIR-form reference CIC model with per-cycle
// comparison, plus directed scenarios with hand-computed expectations.
module tb_pdm_cic_decimator;

    localparam int BW    = 8;
    localparam int NM    = 9;
    localparam int LD    = 6;
    localparam int PD    = 4;
    localparam int DECIM = 64;
    localparam int HL    = 3 * (DECIM - 1) + 1;
    localparam longint YMAX = (longint'(1) << (3 * LD)) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [NM-1:0] pdm;
    logic          mic_clk;
    logic [BW-1:0] pcm [0:NM-1];
    logic          pcm_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int n_print = 0;

    always #5 clk = ~clk;

    pdm_cic_decimator #(
        .BIT_WIDTH (BW),
        .NUM_MICS  (NM),
        .LOG2_DECIM(LD),
        .PDM_DIV   (PD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pdm_data_in (pdm),
        .mic_clk     (mic_clk),
        .pcm_data_out(pcm),
        .pcm_valid   (pcm_valid)
    );

    // ---------------- reference model ----------------
    // Impulse response of three cascaded length-DECIM boxcars.
    int h [HL];
    int b2 [2*DECIM-1];
    logic [NM-1:0] hist [$];

    int            m_en_prev;
    int            m_k;
    int            m_s;
    int            m_warm;
    bit            m_pend;
    logic [BW-1:0] m_pend_val [NM];
    logic [BW-1:0] exp_pcm [NM];
    logic          exp_valid;
    logic          exp_mic;

    function automatic logic [BW-1:0] fir_code(input int mic);
        longint acc;
        int n;
        acc = 0;
        n = hist.size();
        for (int j = 0; j < HL; j++) begin
            if (n - 1 - j >= 0) acc += longint'(h[j]) * longint'(hist[n-1-j][mic]);
        end
        if (acc > YMAX) acc = YMAX;
        return BW'(acc >> (3 * LD - BW));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_en_prev = 0;
            m_k = 0;
            m_s = 0;
            m_warm = 0;
            m_pend = 0;
            exp_valid = 1'b0;
            exp_mic = 1'b0;
            for (int m = 0; m < NM; m++) exp_pcm[m] = '0;
            hist.delete();
        end else begin
            exp_valid = 1'b0;
            if (enable) begin
                if (m_en_prev == 0) begin
                    m_k = 0;
                    m_s = 0;
                    m_warm = 0;
                end
                if (m_pend) begin
                    if (m_warm == 3) begin
                        exp_pcm = m_pend_val;
                        exp_valid = 1'b1;
                    end else begin
                        m_warm++;
                    end
                end
                m_pend = 0;
                m_k++;
                if (m_k % PD == 0) begin
                    hist.push_back(pdm);
                    m_s++;
                    if (m_s % DECIM == 0) begin
                        m_pend = 1;
                        for (int m = 0; m < NM; m++) m_pend_val[m] = fir_code(m);
                    end
                end
                exp_mic = ((m_k % PD) < PD / 2);
            end else begin
                m_pend = 0;
                exp_mic = 1'b0;
            end
            m_en_prev = enable ? 1 : 0;
        end
    end

    // ---------------- per-cycle scoreboard ----------------
    always @(posedge clk) begin
        logic [NM*BW-1:0] gv;
        logic [NM*BW-1:0] ev;
        #2;
        for (int m = 0; m < NM; m++) begin
            gv[m*BW +: BW] = pcm[m];
            ev[m*BW +: BW] = exp_pcm[m];
        end
        n_cmp++;
        if (pcm_valid !== exp_valid || mic_clk !== exp_mic || gv !== ev) begin
            n_bad++;
            if (n_print < 20) begin
                n_print++;
                $display("FAIL cycle t=%0t got valid=%b mic=%b pcm=%h, expected valid=%b mic=%b pcm=%h",
                         $time, pcm_valid, mic_clk, gv, exp_valid, exp_mic, ev);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!pcm_valid && n < 1100);
        if (!pcm_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL valid_timeout: no pcm_valid within %0d cycles", n);
        end
    endtask

    // ---------------- stimulus driver ----------------
    int mode = 0;   // 0 ones, 1 zeros, 2 alternating/ones, 3 random 25%
    initial begin
        logic tog;
        pdm = '1;
        tog = 1'b0;
        forever begin
            repeat (PD) @(negedge clk);
            case (mode)
                0: pdm = '1;
                1: pdm = '0;
                2: begin
                    for (int m = 0; m < NM; m++) pdm[m] = (m % 2 == 1) ? 1'b1 : tog;
                    tog = ~tog;
                end
                default: for (int m = 0; m < NM; m++) pdm[m] = ($urandom_range(0, 3) == 0);
            endcase
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int sum_h;
        int sum_even;
        int acc_code;
        int n_hi;
        int n_vl;

        for (int i = 0; i < DECIM; i++)
            for (int j = 0; j < DECIM; j++) b2[i+j]++;
        for (int k = 0; k < 2*DECIM-1; k++)
            for (int l = 0; l < DECIM; l++) h[k+l] += b2[k];

        // Model pinning: boxcar^3 coefficients and their sums.
        sum_h = 0;
        sum_even = 0;
        for (int k = 0; k < HL; k++) begin
            sum_h += h[k];
            if (k % 2 == 0) sum_even += h[k];
        end
        check("h0", h[0], 1);
        check("h1", h[1], 3);
        check("h2", h[2], 6);
        check("h_last", h[HL-1], 1);
        check("h_sum", sum_h, 262144);
        check("h_even_sum", sum_even, 131072);

        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(pcm_valid), 0);
        check("rst_mic", int'(mic_clk), 0);
        for (int m = 0; m < NM; m++) check($sformatf("rst_pcm%0d", m), int'(pcm[m]), 0);

        // All ones: first output after warm-up, then one per period.
        rst = 1'b0;
        enable = 1'b1;
        wait_valid(n);
        check("first_valid_cycles", n, 1025);
        for (int m = 0; m < NM; m++) check($sformatf("ones_pcm%0d", m), int'(pcm[m]), 255);
        wait_valid(n);
        check("period_cycles", n, 256);

        // All zeros.
        mode = 1;
        repeat (5) wait_valid(n);
        check("zeros_period", n, 256);
        for (int m = 0; m < NM; m++) check($sformatf("zeros_pcm%0d", m), int'(pcm[m]), 0);

        // Even mics alternate, odd mics all ones.
        mode = 2;
        repeat (5) wait_valid(n);
        for (int m = 0; m < NM; m++)
            check($sformatf("pattern_pcm%0d", m), int'(pcm[m]), (m % 2 == 1) ? 255 : 128);

        // Asynchronous reset around sample 30 of a period.
        mode = 0;
        wait_valid(n);
        repeat (118) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(pcm_valid), 0);
        check("async_rst_mic", int'(mic_clk), 0);
        for (int m = 0; m < NM; m++) check($sformatf("async_rst_pcm%0d", m), int'(pcm[m]), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_valid(n);
        check("post_rst_valid_cycles", n, 1025);
        check("post_rst_pcm0", int'(pcm[0]), 255);

        // Enable pause of 100 cycles mid-period.
        wait_valid(n);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        n_hi = 0;
        n_vl = 0;
        repeat (100) begin
            @(negedge clk);
            n_hi += int'(mic_clk);
            n_vl += int'(pcm_valid);
        end
        check("paused_mic_high", n_hi, 0);
        check("paused_valids", n_vl, 0);
        enable = 1'b1;
        wait_valid(n);
        check("reenable_valid_cycles", n, 1025);
        for (int m = 0; m < NM; m++) check($sformatf("reenable_pcm%0d", m), int'(pcm[m]), 255);

        // Random 25% density: bit-true against the model via the scoreboard.
        mode = 3;
        acc_code = 0;
        for (int i = 0; i < 53; i++) begin
            wait_valid(n);
            if (i >= 3)
                for (int m = 0; m < NM; m++) acc_code += int'(pcm[m]);
        end
        check("random_mean_in_range",
              int'((acc_code / (50 * NM)) >= 56 && (acc_code / (50 * NM)) <= 72), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
